// File: rtl/fwd_pkg.sv
// Shared types and encodings for the EX-stage forwarding and load-use hazard unit.
package fwd_pkg;

    // Shadow stages hold register indices at this fixed width; narrower indices are zero-extended.
    localparam int RD_W = 8;

    typedef enum logic [2:0] {
        FWD_REG   = 3'b000,
        FWD_IMM   = 3'b001,
        FWD_PC    = 3'b010,
        FWD_EXMEM = 3'b110,
        FWD_MEMWB = 3'b101
    } fwd_sel_e;

    localparam logic       ALUSRC_A_RS1 = 1'b0;
    localparam logic       ALUSRC_A_PC  = 1'b1;
    localparam logic [1:0] ALUSRC_B_RS2 = 2'b00;
    localparam logic [1:0] ALUSRC_B_IMM = 2'b01;
    localparam logic [1:0] ALUSRC_B_PC  = 2'b10;

    typedef enum logic [1:0] {
        SRC_REG = 2'd0,
        SRC_IMM = 2'd1,
        SRC_PC  = 2'd2
    } src_kind_e;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } stage_t;

endpackage

// File: rtl/fwd_match.sv
// Per-operand select and load-hit logic, evaluated in ID against the EX and MEM shadow stages.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [RD_W-1:0] rs,
    input  src_kind_e       kind,
    input  stage_t          ex_stage,
    input  stage_t          mem_stage,
    output logic [2:0]      sel_next,
    output logic            load_hit
);

    logic ex_hit;
    logic mem_hit;
    logic unused_mem_memread;

    assign unused_mem_memread = mem_stage.memread;

    always_comb begin
        // NOTE: every output gets a default first, so no path through this block can infer a latch.
        sel_next = FWD_REG;
        ex_hit   = (rs != '0) && ex_stage.valid && ex_stage.regwrite && (ex_stage.rd == rs);
        mem_hit  = (rs != '0) && mem_stage.valid && mem_stage.regwrite && (mem_stage.rd == rs);
        load_hit = (kind == SRC_REG) && (rs != '0) && ex_stage.valid && ex_stage.memread
                   && (ex_stage.rd == rs);

        if (kind == SRC_IMM) begin
            sel_next = FWD_IMM;
        end else if (kind == SRC_PC) begin
            sel_next = FWD_PC;
        end else if (ex_hit) begin
            sel_next = FWD_EXMEM;
        end else if (mem_hit) begin
            sel_next = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Registers EX operand forwarding selects and inserts one bubble on a load-use hazard.
// Define FWD_STALL_CNT_EN to add the saturating stall_count_o counter.
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_alusrc_a,
    input  logic [1:0]            id_alusrc_b,
    input  logic                  flush_i,
    output logic [2:0]            sel_ForwardA,
    output logic [2:0]            sel_ForwardB,
    output logic                  stall_o,
    output logic                  ex_bubble_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [XLEN-1:0]       stall_count_o
`endif
);

    stage_t          ex_q;
    stage_t          mem_q;
    stage_t          wb_q;
    stage_t          id_stage;
    logic [RD_W-1:0] rs1_ext;
    logic [RD_W-1:0] rs2_ext;
    src_kind_e       kind_a;
    src_kind_e       kind_b;
    logic [2:0]      sel_a_next;
    logic [2:0]      sel_b_next;
    logic            load_hit_a;
    logic            load_hit_b;
    logic            insert_bubble;
    logic            unused_wb;

    always_comb begin
        rs1_ext                   = '0;
        rs2_ext                   = '0;
        rs1_ext[REG_ADDR_W-1:0]   = id_rs1;
        rs2_ext[REG_ADDR_W-1:0]   = id_rs2;
        id_stage                  = '0;
        id_stage.valid            = 1'b1;
        id_stage.rd[REG_ADDR_W-1:0] = id_rd;
        id_stage.regwrite         = id_regwrite;
        id_stage.memread          = id_memread;

        kind_a = (id_alusrc_a == ALUSRC_A_PC) ? SRC_PC : SRC_REG;
        // Encoding 11 on operand B falls through to the register path.
        case (id_alusrc_b)
            ALUSRC_B_IMM: kind_b = SRC_IMM;
            ALUSRC_B_PC:  kind_b = SRC_PC;
            default:      kind_b = SRC_REG;
        endcase
    end

    fwd_match u_match_a (
        .rs        (rs1_ext),
        .kind      (kind_a),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .sel_next  (sel_a_next),
        .load_hit  (load_hit_a)
    );

    fwd_match u_match_b (
        .rs        (rs2_ext),
        .kind      (kind_b),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .sel_next  (sel_b_next),
        .load_hit  (load_hit_b)
    );

    // A flush kills the ID instruction, so it can never be the consumer of a hazard.
    assign stall_o       = id_valid & ~flush_i & (load_hit_a | load_hit_b);
    assign insert_bubble = stall_o | flush_i | ~id_valid;

    // Write-back slot is kept for visibility of the full shadow pipeline; nothing consumes it yet.
    assign unused_wb = ^wb_q;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
        if (reset) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            sel_ForwardA <= FWD_REG;
            sel_ForwardB <= FWD_REG;
            ex_bubble_o  <= 1'b1;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (insert_bubble) begin
                ex_q         <= '0;
                sel_ForwardA <= FWD_REG;
                sel_ForwardB <= FWD_REG;
                ex_bubble_o  <= 1'b1;
            end else begin
                ex_q         <= id_stage;
                sel_ForwardA <= sel_a_next;
                sel_ForwardB <= sel_b_next;
                ex_bubble_o  <= 1'b0;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_o <= '0;
        end else if (stall_o && (stall_count_o != '1)) begin
            stall_count_o <= stall_count_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench: directed pipeline scenarios plus random instruction streams against a queue model.
module tb_forward_hazard_unit;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    logic                  clk;
    logic                  reset;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_alusrc_a;
    logic [1:0]            id_alusrc_b;
    logic                  flush_i;
    logic [2:0]            sel_ForwardA;
    logic [2:0]            sel_ForwardB;
    logic                  stall_o;
    logic                  ex_bubble_o;
`ifdef FWD_STALL_CNT_EN
    logic [XLEN-1:0]       stall_count_o;
`endif

    forward_hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .XLEN       (XLEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_regwrite   (id_regwrite),
        .id_memread    (id_memread),
        .id_alusrc_a   (id_alusrc_a),
        .id_alusrc_b   (id_alusrc_b),
        .flush_i       (flush_i),
        .sel_ForwardA  (sel_ForwardA),
        .sel_ForwardB  (sel_ForwardB),
        .stall_o       (stall_o),
        .ex_bubble_o   (ex_bubble_o)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_count_o (stall_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of instructions that entered EX, newest first (0 = EX, 1 = MEM, 2 = WB).
    typedef struct {
        bit valid;
        int rd;
        bit regwrite;
        bit memread;
    } slot_t;

    slot_t           pipe[$];
    bit [2:0]        exp_sel_a;
    bit [2:0]        exp_sel_b;
    bit              exp_bubble;
    logic [XLEN-1:0] exp_count;
    logic            last_stall;
    int              checks_total;
    int              checks_passed;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic model_reset();
        slot_t empty;
        empty = '{1'b0, 0, 1'b0, 1'b0};
        pipe.delete();
        repeat (3) pipe.push_back(empty);
        exp_sel_a  = 3'b000;
        exp_sel_b  = 3'b000;
        exp_bubble = 1'b1;
        exp_count  = '0;
    endtask

    function automatic bit writes(input slot_t s, input int rs);
        return (rs != 0) && s.valid && s.regwrite && (s.rd == rs);
    endfunction

    function automatic bit [2:0] model_sel(input bit is_a, input int rs, input bit asa, input bit [1:0] asb);
        if (is_a && asa) return 3'b010;
        if (!is_a && asb == 2'b01) return 3'b001;
        if (!is_a && asb == 2'b10) return 3'b010;
        if (writes(pipe[0], rs)) return 3'b110;
        if (writes(pipe[1], rs)) return 3'b101;
        return 3'b000;
    endfunction

    function automatic bit model_stall(input bit v, input int rs1, input int rs2,
                                       input bit asa, input bit [1:0] asb, input bit fl);
        bit uses_rs1;
        bit uses_rs2;
        if (!v || fl || !pipe[0].valid || !pipe[0].memread || pipe[0].rd == 0) return 1'b0;
        uses_rs1 = !asa && (rs1 == pipe[0].rd);
        uses_rs2 = (asb == 2'b00 || asb == 2'b11) && (rs2 == pipe[0].rd);
        return uses_rs1 || uses_rs2;
    endfunction

    // One ID slot; called just after a rising edge, returns just after the next one.
    task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit rw,
                        input bit mr, input bit asa, input bit [1:0] asb, input bit fl);
        bit       s;
        bit [2:0] na;
        bit [2:0] nb;
        slot_t    n;
        id_valid    = v;
        id_rs1      = rs1[REG_ADDR_W-1:0];
        id_rs2      = rs2[REG_ADDR_W-1:0];
        id_rd       = rd[REG_ADDR_W-1:0];
        id_regwrite = rw;
        id_memread  = mr;
        id_alusrc_a = asa;
        id_alusrc_b = asb;
        flush_i     = fl;
        s  = model_stall(v, rs1, rs2, asa, asb, fl);
        na = model_sel(1'b1, rs1, asa, asb);
        nb = model_sel(1'b0, rs2, asa, asb);
        #2;
        last_stall = stall_o;
        check("stall", stall_o, s);
        @(posedge clk);
        if (s || fl || !v) begin
            n = '{1'b0, 0, 1'b0, 1'b0};
            exp_sel_a  = 3'b000;
            exp_sel_b  = 3'b000;
            exp_bubble = 1'b1;
        end else begin
            n = '{1'b1, rd, rw, mr};
            exp_sel_a  = na;
            exp_sel_b  = nb;
            exp_bubble = 1'b0;
        end
        if (s && exp_count != '1) exp_count = exp_count + 1;
        pipe.push_front(n);
        void'(pipe.pop_back());
        #1;
        check("sel_a", sel_ForwardA, exp_sel_a);
        check("sel_b", sel_ForwardB, exp_sel_b);
        check("bubble", ex_bubble_o, exp_bubble);
`ifdef FWD_STALL_CNT_EN
        check("count", stall_count_o, exp_count);
`endif
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        step(1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic load(input int rd, input int rs1);
        step(1'b1, rs1, 0, rd, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    endtask

    task automatic nop();
        step(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        last_stall    = 1'b0;
        reset         = 1'b1;
        id_valid      = 1'b0;
        id_rs1        = '0;
        id_rs2        = '0;
        id_rd         = '0;
        id_regwrite   = 1'b0;
        id_memread    = 1'b0;
        id_alusrc_a   = 1'b0;
        id_alusrc_b   = 2'b00;
        flush_i       = 1'b0;
        model_reset();

        #3;
        check("rst_sel_a", sel_ForwardA, 3'b000);
        check("rst_sel_b", sel_ForwardB, 3'b000);
        check("rst_bubble", ex_bubble_o, 1'b1);
        check("rst_stall", stall_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // EX/MEM forwarding into both operands.
        alu(5, 1, 2);
        alu(6, 5, 5);
        check("tp1_a", sel_ForwardA, 3'b110);
        check("tp1_b", sel_ForwardB, 3'b110);
        check("tp1_stall", last_stall, 1'b0);

        // MEM/WB forwarding; x0 never forwards.
        alu(5, 1, 2);
        nop();
        alu(7, 0, 5);
        check("tp2_a", sel_ForwardA, 3'b000);
        check("tp2_b", sel_ForwardB, 3'b101);

        // Load-use: one stall, one bubble, then MEM/WB forwarding.
        nop();
        nop();
        load(8, 2);
        alu(9, 8, 1);
        check("tp3_stall", last_stall, 1'b1);
        check("tp3_bubble", ex_bubble_o, 1'b1);
        check("tp3_sel_a", sel_ForwardA, 3'b000);
        alu(9, 8, 1);
        check("tp3_restall", last_stall, 1'b0);
        check("tp3_fwd_a", sel_ForwardA, 3'b101);
`ifdef FWD_STALL_CNT_EN
        check("tp3_count", stall_count_o, 1);
`endif

        // Immediate operand B with EX/MEM forwarding on A.
        alu(10, 3, 4);
        step(1'b1, 10, 0, 10, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        check("tp4_b", sel_ForwardB, 3'b001);
        check("tp4_a", sel_ForwardA, 3'b110);

        // Flush wins over a load-use hazard; the load still advances.
        nop();
        nop();
        load(12, 1);
        step(1'b1, 12, 3, 13, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        check("tp5_stall", last_stall, 1'b0);
        check("tp5_bubble", ex_bubble_o, 1'b1);
        alu(14, 12, 0);
        check("tp5_fwd_a", sel_ForwardA, 3'b101);

        // Reset asserted during a stall cycle.
        nop();
        nop();
        load(15, 1);
        id_valid    = 1'b1;
        id_rs1      = 5'd15;
        id_rs2      = 5'd2;
        id_rd       = 5'd16;
        id_regwrite = 1'b1;
        id_memread  = 1'b0;
        id_alusrc_a = 1'b0;
        id_alusrc_b = 2'b00;
        flush_i     = 1'b0;
        #2;
        check("tp6_pre_stall", stall_o, 1'b1);
        reset = 1'b1;
        #1;
        check("tp6_stall", stall_o, 1'b0);
        check("tp6_sel_a", sel_ForwardA, 3'b000);
        check("tp6_sel_b", sel_ForwardB, 3'b000);
        check("tp6_bubble", ex_bubble_o, 1'b1);
`ifdef FWD_STALL_CNT_EN
        check("tp6_count", stall_count_o, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        alu(9, 15, 15);
        check("tp6_post_a", sel_ForwardA, 3'b000);
        check("tp6_post_b", sel_ForwardB, 3'b000);

        // Random instruction stream over a small register set to provoke frequent hits.
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit mr;
            bit rw;
            v  = ($urandom_range(0, 9) != 0);
            mr = ($urandom_range(0, 2) == 0);
            rw = mr || ($urandom_range(0, 3) != 0);
            step(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rw, mr,
                 ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
